ifetch_unit: RTL

//   Instruction-fetch responder for the control unit's fetch strobes.
//   - Owns the PC; reacts to imem_read / pc_inc / jump.
//   - Issues requests to instruction memory over a req/rvalid handshake.
//   - Returns the fetched word on ir, which feeds the control unit's ir input.
//   - Sits between the control unit and instruction memory; buffers one fetch that arrives while busy.

---
 rtl/ifetch_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// Instruction-fetch responder: owns the PC, issues req/rvalid fetches and buffers one extra strobe.
// Optional IFETCH_FLUSH_ON_JUMP_EN: a jump while waiting discards the in-flight and pending fetches.
module ifetch_unit #(
    parameter int unsigned         BUS_WIDTH = 16,
    parameter int unsigned         PC_WIDTH  = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 imem_read,
    input  logic                 pc_inc,
    input  logic                 jump,
    input  logic [PC_WIDTH-1:0]  jump_addr,
    output logic                 mem_req,
    output logic [PC_WIDTH-1:0]  mem_addr,
    input  logic [BUS_WIDTH-1:0] mem_rdata,
    input  logic                 mem_rvalid,
    output logic [PC_WIDTH-1:0]  pc,
    output logic [BUS_WIDTH-1:0] ir,
    output logic                 ir_valid,
    output logic                 busy,
    output logic                 overrun
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e               state_q, state_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [BUS_WIDTH-1:0] ir_q, ir_d;
    logic                 ir_valid_q, ir_valid_d;
    logic                 mem_req_q, mem_req_d;
    logic [PC_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [PC_WIDTH-1:0]  pend_addr_q, pend_addr_d;
    logic                 pending_q, pending_d;
    logic                 overrun_q, overrun_d;
    logic                 pend_v;
    logic                 deliver;
`ifdef IFETCH_FLUSH_ON_JUMP_EN
    logic                 stale_q, stale_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            ir_valid_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            pend_addr_q <= '0;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef IFETCH_FLUSH_ON_JUMP_EN
            stale_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            ir_valid_q  <= ir_valid_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            pend_addr_q <= pend_addr_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
`ifdef IFETCH_FLUSH_ON_JUMP_EN
            stale_q     <= stale_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        ir_valid_d  = 1'b0;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        pend_addr_d = pend_addr_q;
        pending_d   = pending_q;
        overrun_d   = overrun_q;
        pend_v      = pending_q;
        deliver     = 1'b1;
`ifdef IFETCH_FLUSH_ON_JUMP_EN
        stale_d = stale_q;
        // A jump on the same edge as the response already makes that response stale.
        if (state_q == StWait && jump) begin
            stale_d = 1'b1;
            pend_v  = 1'b0;
        end
        deliver = !stale_d;
`endif

        if (jump) begin
            pc_d = jump_addr;
        end else if (pc_inc) begin
            pc_d = pc_q + PC_WIDTH'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (imem_read) begin
                    mem_addr_d = pc_q;
                    mem_req_d  = 1'b1;
                    state_d    = StWait;
                end
            end
            StWait: begin
                pending_d = pend_v;
                if (mem_rvalid) begin
                    if (deliver) begin
                        ir_d       = mem_rdata;
                        ir_valid_d = 1'b1;
                    end
`ifdef IFETCH_FLUSH_ON_JUMP_EN
                    stale_d = 1'b0;
`endif
                    // The buffer slot frees on this edge, so a coincident strobe is never dropped.
                    if (pend_v) begin
                        mem_addr_d = pend_addr_q;
                        pending_d  = imem_read;
                        if (imem_read) begin
                            pend_addr_d = pc_q;
                        end
                    end else if (imem_read) begin
                        mem_addr_d = pc_q;
                    end else begin
                        mem_req_d = 1'b0;
                        state_d   = StIdle;
                    end
                end else if (imem_read) begin
                    if (pend_v) begin
                        overrun_d = 1'b1;
                    end else begin
                        pend_addr_d = pc_q;
                        pending_d   = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign pc       = pc_q;
    assign ir       = ir_q;
    assign ir_valid = ir_valid_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign busy     = (state_q == StWait);
    assign overrun  = overrun_q;

endmodule
